// File: rtl/gameover_sequencer.sv
// Game-flow controller: TITLE -> PLAY -> ARM -> GAMEOVER -> TITLE.
// Produces the per-frame timer tick from VGA vsync, launches the game-over
// timer on player death and leaves the game-over screen when the timer
// expires, or after a bounded number of frames if it never does.
module gameover_sequencer #(
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned MAX_WAIT_TICKS   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       start_btn,
    input  logic       player_dead,
    input  logic       timer_done,
    output logic       timer_start,
    output logic       timer_tick,
    output logic       game_reset,
    output logic       game_active,
    output logic       gameover_display,
    output logic [1:0] state,
    output logic       timeout_flag
);

    typedef enum logic [1:0] {
        TITLE    = 2'd0,
        PLAY     = 2'd1,
        ARM      = 2'd2,
        GAMEOVER = 2'd3
    } state_t;

    // Vsync level while no frame boundary is in progress, and the level the
    // line moves to at the frame boundary we tick on.
    localparam logic       IDLE_LVL = VSYNC_ACTIVE_LOW;
    localparam logic       ACT_LVL  = ~VSYNC_ACTIVE_LOW;
    localparam logic [7:0] MAX_WAIT = 8'(MAX_WAIT_TICKS);

    state_t     state_q;
    logic       vs_sync1;
    logic       vs_sync2;
    logic       vs_edge_q;
    logic [7:0] wait_cnt;

    assign state = state_q;

    // Vsync synchronizer and active-edge detector producing a one-cycle tick.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the
    // synchronizer chain into a single stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Idle level everywhere so releasing reset cannot fake an edge.
            vs_sync1   <= IDLE_LVL;
            vs_sync2   <= IDLE_LVL;
            vs_edge_q  <= IDLE_LVL;
            timer_tick <= 1'b0;
        end else begin
            vs_sync1   <= vsync;
            vs_sync2   <= vs_sync1;
            vs_edge_q  <= vs_sync2;
            timer_tick <= (vs_sync2 == ACT_LVL) && (vs_edge_q != ACT_LVL);
        end
    end

    // Game-flow FSM; every output is registered and updated on the transition
    // into the state it belongs to.
    // NOTE: reset here is synchronous, so it only takes effect on a clock edge;
    // the clock must run while reset is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= TITLE;
            timer_start      <= 1'b0;
            game_reset       <= 1'b0;
            game_active      <= 1'b0;
            gameover_display <= 1'b0;
            timeout_flag     <= 1'b0;
            wait_cnt         <= 8'd0;
        end else begin
            // Pulse outputs default low; only a transition raises them.
            timer_start <= 1'b0;
            game_reset  <= 1'b0;
            case (state_q)
                TITLE: begin
                    if (start_btn) begin
                        state_q     <= PLAY;
                        game_reset  <= 1'b1;
                        game_active <= 1'b1;
                    end
                end
                PLAY: begin
                    if (player_dead) begin
                        state_q          <= ARM;
                        timer_start      <= 1'b1;
                        game_active      <= 1'b0;
                        gameover_display <= 1'b1;
                    end
                end
                ARM: begin
                    // The timer loads on this edge, so timer_done is not
                    // looked at until its fresh value is visible.
                    state_q  <= GAMEOVER;
                    wait_cnt <= 8'd0;
                end
                GAMEOVER: begin
                    if (timer_done) begin
                        state_q          <= TITLE;
                        gameover_display <= 1'b0;
                    end else if (wait_cnt == MAX_WAIT) begin
                        state_q          <= TITLE;
                        gameover_display <= 1'b0;
                        timeout_flag     <= 1'b1;
                    end else if (timer_tick && (wait_cnt != 8'hFF)) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state_q <= TITLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gameover_sequencer.sv
// Directed testbench for gameover_sequencer. The main instance runs against a
// small model of the two-second game-over timer; a second instance with a
// short wait limit and a stuck timer_done exercises the forced-exit path.
module tb_gameover_sequencer;

    localparam int TIMER_LOAD = 120;
    localparam int VS_HALF    = 8;

    logic clk = 1'b0;
    logic vsync = 1'b1;

    // Main instance (default wait limit, timer model attached).
    logic       reset = 1'b1;
    logic       start_btn = 1'b0;
    logic       player_dead = 1'b0;
    logic       timer_done;
    logic       timer_start, timer_tick, game_reset, game_active;
    logic       gameover_display, timeout_flag;
    logic [1:0] state;

    // Short-limit instance, timer_done driven directly.
    logic       reset5 = 1'b1;
    logic       start5 = 1'b0;
    logic       dead5 = 1'b0;
    logic       done5 = 1'b0;
    logic       timer_start5, timer_tick5, game_reset5, game_active5;
    logic       gameover_display5, timeout_flag5;
    logic [1:0] state5;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_fall = 0;
    int tmr_cnt = 0;

    gameover_sequencer #(
        .VSYNC_ACTIVE_LOW (1'b1),
        .MAX_WAIT_TICKS   (255)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .vsync            (vsync),
        .start_btn        (start_btn),
        .player_dead      (player_dead),
        .timer_done       (timer_done),
        .timer_start      (timer_start),
        .timer_tick       (timer_tick),
        .game_reset       (game_reset),
        .game_active      (game_active),
        .gameover_display (gameover_display),
        .state            (state),
        .timeout_flag     (timeout_flag)
    );

    gameover_sequencer #(
        .VSYNC_ACTIVE_LOW (1'b1),
        .MAX_WAIT_TICKS   (5)
    ) u_dut5 (
        .clk              (clk),
        .reset            (reset5),
        .vsync            (vsync),
        .start_btn        (start5),
        .player_dead      (dead5),
        .timer_done       (done5),
        .timer_start      (timer_start5),
        .timer_tick       (timer_tick5),
        .game_reset       (game_reset5),
        .game_active      (game_active5),
        .gameover_display (gameover_display5),
        .state            (state5),
        .timeout_flag     (timeout_flag5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scaled vsync: 16-cycle frame, falling (active) edge recorded by cycle.
    initial begin
        forever begin
            repeat (VS_HALF) @(negedge clk);
            vsync = ~vsync;
            if (!vsync) last_fall = cyc;
        end
    end

    // Game-over timer model: load on start, count down on ticks, done at zero.
    always @(posedge clk) begin
        if (timer_start) tmr_cnt <= TIMER_LOAD;
        else if (timer_tick && tmr_cnt != 0) tmr_cnt <= tmr_cnt - 1;
    end
    assign timer_done = (tmr_cnt == 0);

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int ticks_in_reset = 0;
        int nticks = 0;
        int bad_lat = 0;
        int wide = 0;
        logic prev_vs;
        logic prev_tick = 1'b0;
        bit found = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step;
            if (timer_tick) ticks_in_reset++;
        end
        checks++; if (ticks_in_reset !== 0) begin failures++; $display("FAIL reset_no_tick got=%0d exp=0", ticks_in_reset); end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if ({timer_start, game_reset, game_active, gameover_display, timeout_flag} !== 5'b0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=00000", {timer_start, game_reset, game_active, gameover_display, timeout_flag});
        end
        // Release reset just after vsync returns to its idle level.
        prev_vs = vsync;
        for (int i = 0; i < 40 && !found; i++) begin
            step;
            if (vsync && !prev_vs) found = 1'b1;
            prev_vs = vsync;
        end
        checks++; if (!found) begin failures++; $display("FAIL reset_vsync_rise got=none exp=rise within 40 cycles"); end
        reset = 1'b0;
        // 64 cycles after a rise cover exactly four falling edges.
        for (int i = 0; i < 64; i++) begin
            step;
            if (timer_tick) begin
                nticks++;
                if (cyc - last_fall < 2 || cyc - last_fall > 4) bad_lat++;
                if (prev_tick) wide++;
            end
            prev_tick = timer_tick;
        end
        checks++; if (nticks !== 4) begin failures++; $display("FAIL tick_count got=%0d exp=4", nticks); end
        checks++; if (bad_lat !== 0) begin failures++; $display("FAIL tick_latency got=%0d bad exp=0", bad_lat); end
        checks++; if (wide !== 0) begin failures++; $display("FAIL tick_width got=%0d wide exp=0", wide); end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL idle_state got=%0d exp=0", state); end
    endtask

    task automatic test_start;
        start_btn = 1'b1;
        step;
        start_btn = 1'b0;
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", state); end
        checks++; if (game_reset !== 1'b1) begin failures++; $display("FAIL start_game_reset got=%b exp=1", game_reset); end
        checks++; if (game_active !== 1'b1) begin failures++; $display("FAIL start_game_active got=%b exp=1", game_active); end
        step;
        checks++; if (game_reset !== 1'b0) begin failures++; $display("FAIL game_reset_width got=%b exp=0", game_reset); end
        // start_btn is ignored in PLAY.
        start_btn = 1'b1;
        step;
        start_btn = 1'b0;
        checks++; if (state !== 2'd1 || game_reset !== 1'b0) begin
            failures++; $display("FAIL play_ignores_start got state=%0d game_reset=%b exp state=1 game_reset=0", state, game_reset);
        end
    endtask

    task automatic test_gameover_timer;
        int ticks = 0;
        int rise = -1;
        // timer_done is still high from the idle timer (stale).
        player_dead = 1'b1;
        step;
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL arm_state got=%0d exp=2", state); end
        checks++; if (timer_start !== 1'b1) begin failures++; $display("FAIL arm_timer_start got=%b exp=1", timer_start); end
        checks++; if (gameover_display !== 1'b1 || game_active !== 1'b0) begin
            failures++; $display("FAIL arm_display got disp=%b active=%b exp disp=1 active=0", gameover_display, game_active);
        end
        step;
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL gameover_state got=%0d exp=3", state); end
        checks++; if (timer_start !== 1'b0) begin failures++; $display("FAIL timer_start_width got=%b exp=0", timer_start); end
        if (timer_tick) ticks++;
        // start_btn is ignored in GAMEOVER; player_dead stays high throughout.
        start_btn = 1'b1;
        step;
        start_btn = 1'b0;
        checks++; if (state !== 2'd3 || game_reset !== 1'b0) begin
            failures++; $display("FAIL gameover_ignores_start got state=%0d game_reset=%b exp state=3 game_reset=0", state, game_reset);
        end
        for (int i = 0; i < 3000 && state == 2'd3; i++) begin
            if (timer_done && rise < 0) rise = cyc;
            if (timer_tick && !timer_done) ticks++;
            step;
        end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL timer_exit_state got=%0d exp=0", state); end
        checks++; if (rise < 0 || cyc !== rise + 1) begin failures++; $display("FAIL timer_exit_latency got=%0d exp=1", cyc - rise); end
        checks++; if (ticks !== TIMER_LOAD) begin failures++; $display("FAIL gameover_ticks got=%0d exp=%0d", ticks, TIMER_LOAD); end
        checks++; if (timeout_flag !== 1'b0 || gameover_display !== 1'b0) begin
            failures++; $display("FAIL timer_exit_flags got timeout=%b disp=%b exp 0 0", timeout_flag, gameover_display);
        end
    endtask

    task automatic test_ignored_inputs;
        int bad = 0;
        // player_dead is still high in TITLE.
        for (int i = 0; i < 4; i++) begin
            step;
            if (state !== 2'd0 || timer_start !== 1'b0 || game_reset !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL title_ignores_dead got=%0d bad cycles exp=0", bad); end
    endtask

    task automatic test_back_to_back;
        // New game while player_dead is still high re-enters ARM (legal).
        start_btn = 1'b1;
        step;
        start_btn = 1'b0;
        checks++; if (state !== 2'd1 || game_reset !== 1'b1) begin
            failures++; $display("FAIL b2b_play got state=%0d game_reset=%b exp state=1 game_reset=1", state, game_reset);
        end
        step;
        player_dead = 1'b0;
        checks++; if (state !== 2'd2 || timer_start !== 1'b1) begin
            failures++; $display("FAIL b2b_arm got state=%0d timer_start=%b exp state=2 timer_start=1", state, timer_start);
        end
        step;
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL b2b_gameover got=%0d exp=3", state); end
    endtask

    task automatic test_reset_mid_game;
        // Reset in GAMEOVER.
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_gameover_state got=%0d exp=0", state); end
        checks++; if ({timer_start, game_reset, gameover_display, timeout_flag} !== 4'b0) begin
            failures++; $display("FAIL reset_gameover_outputs got=%b exp=0000", {timer_start, game_reset, gameover_display, timeout_flag});
        end
        // Reset in PLAY.
        start_btn = 1'b1;
        step;
        start_btn = 1'b0;
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        checks++; if (state !== 2'd0 || game_active !== 1'b0) begin
            failures++; $display("FAIL reset_play got state=%0d active=%b exp state=0 active=0", state, game_active);
        end
        checks++; if (game_reset !== 1'b0 || timer_start !== 1'b0) begin
            failures++; $display("FAIL reset_play_pulses got game_reset=%b timer_start=%b exp 0 0", game_reset, timer_start);
        end
    endtask

    task automatic test_timeout;
        int ticks = 0;
        reset5 = 1'b0;
        start5 = 1'b1;
        step;
        start5 = 1'b0;
        checks++; if (state5 !== 2'd1 || game_reset5 !== 1'b1 || game_active5 !== 1'b1) begin
            failures++; $display("FAIL to_play got state=%0d game_reset=%b active=%b exp 1 1 1", state5, game_reset5, game_active5);
        end
        dead5 = 1'b1;
        step;
        dead5 = 1'b0;
        checks++; if (timer_start5 !== 1'b1) begin failures++; $display("FAIL to_timer_start got=%b exp=1", timer_start5); end
        step;
        for (int i = 0; i < 500 && state5 == 2'd3; i++) begin
            if (timer_tick5) ticks++;
            step;
        end
        checks++; if (state5 !== 2'd0) begin failures++; $display("FAIL timeout_exit_state got=%0d exp=0", state5); end
        checks++; if (ticks !== 5) begin failures++; $display("FAIL timeout_ticks got=%0d exp=5", ticks); end
        checks++; if (timeout_flag5 !== 1'b1 || gameover_display5 !== 1'b0) begin
            failures++; $display("FAIL timeout_flag got flag=%b disp=%b exp flag=1 disp=0", timeout_flag5, gameover_display5);
        end
        // A further game with a normal exit keeps the flag.
        start5 = 1'b1;
        step;
        start5 = 1'b0;
        dead5 = 1'b1;
        step;
        dead5 = 1'b0;
        step;
        checks++; if (state5 !== 2'd3 || timeout_flag5 !== 1'b1) begin
            failures++; $display("FAIL sticky_in_game got state=%0d flag=%b exp state=3 flag=1", state5, timeout_flag5);
        end
        done5 = 1'b1;
        step;
        done5 = 1'b0;
        checks++; if (state5 !== 2'd0 || timeout_flag5 !== 1'b1) begin
            failures++; $display("FAIL sticky_after_exit got state=%0d flag=%b exp state=0 flag=1", state5, timeout_flag5);
        end
        reset5 = 1'b1;
        step;
        reset5 = 1'b0;
        checks++; if (timeout_flag5 !== 1'b0) begin failures++; $display("FAIL flag_cleared_by_reset got=%b exp=0", timeout_flag5); end
    endtask

    initial begin
        test_reset;
        test_start;
        test_gameover_timer;
        test_ignored_inputs;
        test_back_to_back;
        test_reset_mid_game;
        test_timeout;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
